// File: rtl/val_rdy_queue.sv
// val_rdy_queue
//   Synchronous FIFO with valid/ready handshakes on both ends. Producers
//   enqueue only while o_enq_rdy is high and consumers dequeue only while
//   o_deq_val is high. There is no bypass path (empty queue) and no pipe path
//   (full queue), so every status output depends on registered state alone.
//
// Parameters
//   p_nbits        message width in bits
//   p_num_entries  queue depth, a power of two and at least 2
//
// Ports
//   i_clk       clock, all state updates on the rising edge
//   i_rst       synchronous active-low reset
//   i_enq_val   producer presents a message
//   o_enq_rdy   queue has a free entry
//   i_enq_msg   enqueue message
//   o_deq_val   queue holds at least one message
//   i_deq_rdy   consumer accepts the head message
//   o_deq_msg   message at the head of the queue
//   o_num_free  number of empty entries

module val_rdy_queue #(
  parameter int p_nbits       = 32,
  parameter int p_num_entries = 2
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_enq_val,
  output logic                             o_enq_rdy,
  input  logic [p_nbits-1:0]               i_enq_msg,
  output logic                             o_deq_val,
  input  logic                             i_deq_rdy,
  output logic [p_nbits-1:0]               o_deq_msg,
  output logic [$clog2(p_num_entries):0]   o_num_free
);

  localparam int c_pw = $clog2(p_num_entries);
  localparam logic [c_pw:0] c_depth = (c_pw + 1)'(p_num_entries);

  logic [p_nbits-1:0] r_entries [p_num_entries];
  logic [c_pw-1:0]    r_enq_ptr;
  logic [c_pw-1:0]    r_deq_ptr;
  logic [c_pw:0]      r_count;

  logic w_enq_fire;
  logic w_deq_fire;

  assign o_enq_rdy  = (r_count != c_depth);
  assign o_deq_val  = (r_count != '0);
  assign o_num_free = c_depth - r_count;
  assign o_deq_msg  = r_entries[r_deq_ptr];

  assign w_enq_fire = i_enq_val & o_enq_rdy;
  assign w_deq_fire = i_deq_rdy & o_deq_val;

  // Pointer and occupancy state. Depth is a power of two, so the pointers
  // wrap from N-1 to 0 by plain overflow.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      r_enq_ptr <= '0;
      r_deq_ptr <= '0;
      r_count   <= '0;
    end else begin
      if (w_enq_fire) r_enq_ptr <= r_enq_ptr + c_pw'(1);
      if (w_deq_fire) r_deq_ptr <= r_deq_ptr + c_pw'(1);
      if (w_enq_fire && !w_deq_fire)      r_count <= r_count + (c_pw + 1)'(1);
      else if (w_deq_fire && !w_enq_fire) r_count <= r_count - (c_pw + 1)'(1);
    end
  end

  // Storage carries no reset; contents behind the pointers are don't-care.
  // The write is still gated by reset so a discarded enqueue never lands.
  always_ff @(posedge i_clk) begin
    if (i_rst && w_enq_fire) r_entries[r_enq_ptr] <= i_enq_msg;
  end

endmodule

// File: tb/tb_val_rdy_queue.sv
module tb_val_rdy_queue;

  localparam int N = 4;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          enq_val;
  logic          enq_rdy;
  logic [W-1:0]  enq_msg;
  logic          deq_val;
  logic          deq_rdy;
  logic [W-1:0]  deq_msg;
  logic [2:0]    num_free;

  int n_checks = 0;
  int n_pass   = 0;

  logic [W-1:0] model_q[$];
  logic [W-1:0] rx[$];

  val_rdy_queue #(.p_nbits(W), .p_num_entries(N)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_enq_val  (enq_val),
    .o_enq_rdy  (enq_rdy),
    .i_enq_msg  (enq_msg),
    .o_deq_val  (deq_val),
    .i_deq_rdy  (deq_rdy),
    .o_deq_msg  (deq_msg),
    .o_num_free (num_free)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         rst;
    logic         ev;
    logic [W-1:0] msg;
    logic         dr;
    logic         e_rdy;
    logic         e_val;
    logic [2:0]   e_free;
    logic         chk_msg;
    logic [W-1:0] e_msg;
  } vec_t;

  vec_t tbl[17];

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // One clock: drive inputs, record any DUT dequeue, advance the reference queue.
  task automatic cycle(input logic r, input logic ev, input logic [W-1:0] msg, input logic dr);
    logic m_enq, m_deq;
    rst = r; enq_val = ev; enq_msg = msg; deq_rdy = dr;
    m_enq = ev && (model_q.size() < N);
    m_deq = dr && (model_q.size() > 0);
    if (r && deq_val && dr) rx.push_back(deq_msg);
    @(posedge clk);
    if (!r) model_q.delete();
    else begin
      if (m_deq) void'(model_q.pop_front());
      if (m_enq) model_q.push_back(msg);
    end
    #1;
  endtask

  task automatic model_check(input string tag);
    chk({tag, ".enq_rdy"}, W'(enq_rdy), W'(model_q.size() != N));
    chk({tag, ".deq_val"}, W'(deq_val), W'(model_q.size() != 0));
    chk({tag, ".num_free"}, W'(num_free), W'(N - model_q.size()));
    if (model_q.size() > 0) chk({tag, ".deq_msg"}, deq_msg, model_q[0]);
  endtask

  task automatic check_rx_seq(input string tag, input int n);
    chk({tag, ".count"}, W'(rx.size()), W'(n));
    for (int i = 0; i < n && i < rx.size(); i++)
      chk($sformatf("%s.msg%0d", tag, i), rx[i], W'(i));
  endtask

  initial begin
    int idx;
    logic ev, dr, acc;

    rst = 1'b0; enq_val = 1'b0; enq_msg = '0; deq_rdy = 1'b0;

    //            rst   ev    msg            dr    rdy   val   free  cm    msg
    tbl[0]  = '{1'b0, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0};
    tbl[1]  = '{1'b0, 1'b1, 32'hAAAA,     1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0};
    tbl[2]  = '{1'b1, 1'b1, 32'hDEADBEEF, 1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 32'hDEADBEEF};
    tbl[3]  = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 32'hDEADBEEF};
    tbl[4]  = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0};
    tbl[5]  = '{1'b1, 1'b1, 32'h1,        1'b0, 1'b1, 1'b1, 3'd3, 1'b1, 32'h1};
    tbl[6]  = '{1'b1, 1'b1, 32'h2,        1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 32'h1};
    tbl[7]  = '{1'b1, 1'b1, 32'h3,        1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h1};
    tbl[8]  = '{1'b1, 1'b1, 32'h4,        1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 32'h1};
    tbl[9]  = '{1'b1, 1'b1, 32'h5,        1'b0, 1'b0, 1'b1, 3'd0, 1'b1, 32'h1};
    tbl[10] = '{1'b1, 1'b1, 32'h5,        1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 32'h2};
    tbl[11] = '{1'b1, 1'b1, 32'h5,        1'b1, 1'b1, 1'b1, 3'd1, 1'b1, 32'h3};
    tbl[12] = '{1'b1, 1'b0, 32'h0,        1'b1, 1'b1, 1'b1, 3'd2, 1'b1, 32'h4};
    tbl[13] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b1, 3'd2, 1'b1, 32'h4};
    tbl[14] = '{1'b1, 1'b1, 32'h6,        1'b0, 1'b1, 1'b1, 3'd1, 1'b1, 32'h4};
    tbl[15] = '{1'b0, 1'b1, 32'h7,        1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0};
    tbl[16] = '{1'b1, 1'b0, 32'h0,        1'b0, 1'b1, 1'b0, 3'd4, 1'b0, 32'h0};

    for (int i = 0; i < 17; i++) begin
      cycle(tbl[i].rst, tbl[i].ev, tbl[i].msg, tbl[i].dr);
      chk($sformatf("vec%0d.enq_rdy", i), W'(enq_rdy), W'(tbl[i].e_rdy));
      chk($sformatf("vec%0d.deq_val", i), W'(deq_val), W'(tbl[i].e_val));
      chk($sformatf("vec%0d.num_free", i), W'(num_free), W'(tbl[i].e_free));
      if (tbl[i].chk_msg) chk($sformatf("vec%0d.deq_msg", i), deq_msg, tbl[i].e_msg);
    end

    // Continuous streaming: 0..19 with both sides always active.
    cycle(1'b0, 1'b0, '0, 1'b0);
    rx.delete();
    for (int i = 0; i < 20; i++) begin
      cycle(1'b1, 1'b1, W'(i), 1'b1);
      model_check("stream");
      if (i > 0) chk("stream.free_steady", W'(num_free), W'(N - 1));
    end
    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 1'b0, '0, 1'b1);
      model_check("stream_drain");
    end
    check_rx_seq("stream", 20);

    // Streaming with a randomly stalling consumer.
    cycle(1'b0, 1'b0, '0, 1'b0);
    rx.delete();
    idx = 0;
    for (int c = 0; c < 300 && rx.size() < 20; c++) begin
      ev  = (idx < 20);
      dr  = 1'($urandom_range(0, 1));
      acc = ev && enq_rdy;
      cycle(1'b1, ev, W'(idx), dr);
      model_check("stall");
      if (acc) idx++;
    end
    check_rx_seq("stall", 20);

    // Fully random traffic with occasional resets.
    for (int c = 0; c < 400; c++) begin
      cycle(($urandom_range(0, 39) != 0), 1'($urandom_range(0, 1)),
            $urandom, 1'($urandom_range(0, 1)));
      model_check("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
